// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction prefetch stage for a small 8-bit core with a 16x8 program
// memory.  Sequential reads are issued to the memory, and each response
// byte is queued together with the address it came from.  The decode stage
// drains the queue head with a valid/ready handshake.  A byte whose upper
// nibble is zero is a HALT: it is still queued and delivered, but fetching
// stops after it.  A redirect from downstream flushes everything and
// restarts fetching at the new target.
//
// Parameters
//   DEPTH           prefetch queue entries (power of two, 2..8)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   mem_rd_en       read strobe to program memory
//   mem_addr        read address, meaningful while mem_rd_en=1 (else 0)
//   mem_rdata       read data, valid one cycle after the strobe cycle
//   redirect_valid  jump request from the downstream pipeline
//   redirect_pc     jump target
//   ir_valid        queue head holds an instruction byte
//   ir_data         instruction byte at queue head (0 when empty)
//   ir_pc           address the head byte came from (0 when empty)
//   ir_ready        decode accepts the head byte this cycle
//   halted          HALT reached and everything drained
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_rd_en,
    output logic [3:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       redirect_valid,
    input  logic [3:0] redirect_pc,
    output logic       ir_valid,
    output logic [7:0] ir_data,
    output logic [3:0] ir_pc,
    input  logic       ir_ready,
    output logic       halted
);

    // Pointer width addresses DEPTH entries; count needs one extra bit so it
    // can represent a completely full queue.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        STOP  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [3:0]    fetch_pc;
    logic [CW-1:0] count;
    logic          inflight;
    logic [3:0]    inflight_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [7:0]    fifo_data [DEPTH];
    logic [3:0]    fifo_pc   [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          rsp_halt;

    // Slots already committed: queued bytes plus the one read in flight.
    // A pop in the current cycle deliberately frees no slot until it has
    // been registered, so the issue decision only uses registered values.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

    // The response arriving this cycle is a HALT byte.  Knowing this in the
    // same cycle lets the read stream stop right after the HALT address
    // instead of over-fetching one byte past it.
    assign rsp_halt = inflight && (mem_rdata[7:4] == 4'b0000);

    // A redirect discards both the response arriving this cycle and any
    // handshake the decode stage performs in the same cycle.
    assign push = inflight && !redirect_valid;
    assign pop  = ir_valid && ir_ready && !redirect_valid;

    // FSM register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and read issue.  Redirect always wins and returns to
    // FETCH from either state.  The rst_n term keeps the strobe low while
    // the block is held in reset, so the first read appears only in the
    // cycle after release.
    always_comb begin
        state_next = state;
        issue      = 1'b0;

        if (redirect_valid) begin
            state_next = FETCH;
        end else if ((state == FETCH) && push && rsp_halt) begin
            state_next = STOP;
        end

        if (rst_n && (state == FETCH) && !redirect_valid && !rsp_halt &&
            (occupancy < DEPTH_W)) begin
            issue = 1'b1;
        end
    end

    assign mem_rd_en = issue;
    assign mem_addr  = issue ? fetch_pc : 4'h0;

    // Fetch pointer, in-flight tracking and queue bookkeeping.  On a
    // redirect the queue is emptied by resetting both pointers, which also
    // makes the next entry land in slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= 4'h0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= 4'h0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            count    <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 4'd1;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only observable while
    // count is non-zero, and count is cleared by reset and redirect.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end

    assign ir_valid = (count != '0);
    assign ir_data  = ir_valid ? fifo_data[rd_ptr] : 8'h00;
    assign ir_pc    = ir_valid ? fifo_pc[rd_ptr]   : 4'h0;
    assign halted   = (state == STOP) && (count == '0) && !inflight;

endmodule
